// File: rtl/conv_pkg.sv
// Shared constants, reader FSM state and FIFO entry type for the conv input-feature path.
// Also holds the modulo-WORD_AMOUNT address adder used by SRAM address generators.
package conv_pkg;
  localparam int WORD_AMOUNT = 3136;
  localparam int DATA_W      = 129;
  localparam int ADDR_W      = $clog2(WORD_AMOUNT);
  localparam int SUM_W       = ADDR_W + 1;

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN, RD_DONE} rd_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] dat;
  } rd_word_t;

  // Operands are expected below WORD_AMOUNT, so one correction step is enough.
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SUM_W'(WORD_AMOUNT)) s = s - SUM_W'(WORD_AMOUNT);
    return s[ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/sram_rd_fifo.sv
// Output buffer for SRAM read words tagged with an end-of-window flag.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: caller must never push when full or pop when empty; count exposed for credit.
module sram_rd_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  rd_word_t         push_word,
  input  logic             pop,
  output rd_word_t         head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rd_word_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; stale entries are masked by count at the top level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  assign head = mem[rd_ptr];

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && count == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
endmodule

// File: rtl/sram_i_reader.sv
// Reads a 2-D window from the input-feature SRAM and streams it out on valid/ready.
// Latency: start edge -> first m_valid two cycles later; 1 word/cycle sustained.
// Backpressure: reads are issued only while FIFO occupancy plus in-flight reads fit the FIFO.
module sram_i_reader
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_len,
  input  logic [ADDR_W-1:0] rows,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              busy,
  output logic              done,
  output logic              sram_rd_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = CNT_W + 1;

  rd_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cfg_len, cfg_rows, cfg_stride;
  logic [ADDR_W-1:0] addr, row_start, col_cnt, row_cnt, nxt_row;
  logic              rd_pend, rd_pend_last;
  logic              row_end, final_addr, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CR_W-1:0]   in_flight;
  rd_word_t          push_word, head;

  assign row_end    = (col_cnt == cfg_len - 1'b1);
  assign final_addr = row_end && (row_cnt == cfg_rows - 1'b1);
  assign nxt_row    = addr_add(row_start, cfg_stride);
  // Pops in the current cycle are deliberately not credited back.
  assign in_flight  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend};

  always_comb begin
    state_nxt   = state;
    sram_rd_req = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (state)
      RD_IDLE: begin
        if (start) state_nxt = (row_len == '0 || rows == '0) ? RD_DONE : RD_ISSUE;
      end
      RD_ISSUE: begin
        busy        = 1'b1;
        sram_rd_req = (in_flight < CR_W'(FIFO_DEPTH));
        if (sram_rd_req && final_addr) state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        busy = 1'b1;
        if (pop && head.last) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        done      = 1'b1;
        state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RD_IDLE;
      cfg_len      <= '0;
      cfg_rows     <= '0;
      cfg_stride   <= '0;
      addr         <= '0;
      row_start    <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_pend      <= sram_rd_req;
      rd_pend_last <= sram_rd_req && final_addr;
      if (state == RD_IDLE && start) begin
        cfg_len    <= row_len;
        cfg_rows   <= rows;
        cfg_stride <= row_stride;
        addr       <= base_addr;
        row_start  <= base_addr;
        col_cnt    <= '0;
        row_cnt    <= '0;
      end else if (sram_rd_req && !final_addr) begin
        if (row_end) begin
          addr      <= nxt_row;
          row_start <= nxt_row;
          col_cnt   <= '0;
          row_cnt   <= row_cnt + 1'b1;
        end else begin
          addr    <= addr_add(addr, ADDR_W'(1));
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  assign sram_addr      = addr;
  assign push_word.last = rd_pend_last;
  assign push_word.dat  = sram_dout;

  sram_rd_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? head.dat : '0;
  assign m_last  = m_valid && head.last;
endmodule
